// File: rtl/accum_dump.sv
// accum_dump: sweeps every entry of the word-count accumulator array through its
// 1-cycle-latency read port and streams (index, value) beats on a valid/ready
// interface with full back-pressure.
//
// Build option: define ACCUM_DUMP_SKIP_ZERO_EN to drop entries whose count is zero
// (the final index is always emitted so every dump still ends with out_last).
module accum_dump #(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dump_kick,
    output logic                  dump_busy,
    output logic [31:0]           ram_addr,
    input  logic [63:0]           ram_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic [63:0]           out_data,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH-1:0] LastIdx = '1;

    typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

    state_e                state_q;
    // MSB set means every index has been issued; the counter never wraps to 0.
    logic [ADDR_WIDTH:0]   rd_idx_q;
    logic                  rd_pend_q;
    logic [ADDR_WIDTH-1:0] pend_idx_q;
    logic                  busy_q;

    logic [ADDR_WIDTH-1:0] fifo_idx_q [2];
    logic [63:0]           fifo_data_q [2];
    logic [1:0]            fifo_last_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    logic                  pop;
    logic                  push;
    logic                  keep;
    logic                  pend_last;
    logic                  credit;
    logic                  issue;
    logic                  last_xfer;
    logic [2:0]            committed;

    // Credit, issue and push/pop decisions for this cycle.
    always_comb begin
        pop       = out_valid & out_ready;
        last_xfer = pop & out_last;
        pend_last = (pend_idx_q == LastIdx);
        // Slots already spoken for after this cycle's pop: buffered plus in flight.
        committed = {1'b0, count_q - {1'b0, pop}} + {2'b00, rd_pend_q};
        credit    = (committed < 3'd2);
        issue     = (state_q == StScan) && !rd_idx_q[ADDR_WIDTH] && credit;
`ifdef ACCUM_DUMP_SKIP_ZERO_EN
        keep      = (ram_q[31:0] != 32'd0) || pend_last;
`else
        keep      = 1'b1;
`endif
        push      = rd_pend_q & keep;
    end

    // Dump sequencer: state, issue counter, in-flight read tracking and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_idx_q   <= '0;
            rd_pend_q  <= 1'b0;
            pend_idx_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            rd_pend_q <= issue;
            if (issue) begin
                pend_idx_q <= rd_idx_q[ADDR_WIDTH-1:0];
                rd_idx_q   <= rd_idx_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (dump_kick) begin
                        state_q  <= StScan;
                        rd_idx_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                StScan: begin
                    if (issue && (rd_idx_q[ADDR_WIDTH-1:0] == LastIdx)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (last_xfer) begin
                        state_q  <= StIdle;
                        rd_idx_q <= '0;
                        busy_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Two-entry output FIFO; the credit rule guarantees a returning read has a slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_idx_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            if (push) begin
                fifo_idx_q[wr_ptr_q]  <= pend_idx_q;
                fifo_data_q[wr_ptr_q] <= ram_q;
                fifo_last_q[wr_ptr_q] <= pend_last;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Output drive: FIFO head and read address (zero whenever idle).
    always_comb begin
        dump_busy = busy_q;
        ram_addr  = busy_q ? 32'(rd_idx_q[ADDR_WIDTH-1:0]) : 32'd0;
        out_valid = (count_q != 2'd0);
        out_index = fifo_idx_q[rd_ptr_q];
        out_data  = fifo_data_q[rd_ptr_q];
        out_last  = fifo_last_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_accum_dump.sv
// Bench for accum_dump with ADDR_WIDTH=4: scenario table plus hand-written corner sequences,
// beats checked against a queue of expected (index, data, last) records.
module tb_accum_dump;

    localparam int unsigned AW = 4;
    localparam int unsigned N  = 16;
`ifdef ACCUM_DUMP_SKIP_ZERO_EN
    localparam int ZeroBeats = 3;
`else
    localparam int ZeroBeats = 16;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          dump_kick;
    logic          dump_busy;
    logic [31:0]   ram_addr;
    logic [63:0]   ram_q;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_index;
    logic [63:0]   out_data;
    logic          out_last;

    always #5 clk = ~clk;

    accum_dump #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .dump_kick (dump_kick),
        .dump_busy (dump_busy),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Array model with one cycle of read latency.
    logic [63:0] mem [N];
    always @(posedge clk) ram_q <= mem[ram_addr[AW-1:0]];

    typedef struct {
        logic [AW-1:0] idx;
        logic [63:0]   data;
        logic          last;
    } beat_t;

    typedef struct {
        int pct;
        bit mid_kick;
        bit zero_mode;
        int exp_beats;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[6];
    int    total   = 0;
    int    bad     = 0;
    int    beats   = 0;
    int    rdy_pct = 100;
    int    cyc     = 0;
    bit    mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sink monitor: payload stability while stalled and in-order beat checking.
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [AW-1:0] pi;
    logic [63:0]   pd;
    logic          pl;
    always @(negedge clk) begin
        if (mon_en) begin
            if (pv && !pr) begin
                chk("stable_valid", 64'(out_valid), 64'd1);
                chk("stable_index", 64'(out_index), 64'(pi));
                chk("stable_data", out_data, pd);
                chk("stable_last", 64'(out_last), 64'(pl));
            end
            if (out_valid && out_ready) begin : take
                beat_t e;
                beats++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got index %0d, expected no beat", out_index);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_index", 64'(out_index), 64'(e.idx));
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", 64'(out_last), 64'(e.last));
                end
            end
        end
        pv = mon_en && out_valid;
        pr = out_ready;
        pi = out_index;
        pd = out_data;
        pl = out_last;
    end

    task automatic step();
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic kick();
        dump_kick = 1'b1;
        step();
        dump_kick = 1'b0;
    endtask

    task automatic preload(input bit zero_mode);
        for (int i = 0; i < N; i++) begin
            if (!zero_mode) mem[i] = {32'(i), 32'(i + 1)};
            else mem[i] = {32'(i + 'hA0), ((i == 3) || (i == 9)) ? 32'(100 + i) : 32'd0};
        end
    endtask

    task automatic expect_dump();
        beat_t e;
        bit    keep;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            keep = 1'b1;
`ifdef ACCUM_DUMP_SKIP_ZERO_EN
            keep = (mem[i][31:0] != 32'd0) || (i == N - 1);
`endif
            e.idx  = AW'(i);
            e.data = mem[i];
            e.last = (i == N - 1);
            if (keep) exp_q.push_back(e);
        end
        beats = 0;
    endtask

    task automatic wait_idle(input bit mid_kick);
        for (int c = 0; c < 400 && dump_busy; c++) begin
            if (mid_kick && c == 5) dump_kick = 1'b1;
            step();
            dump_kick = 1'b0;
        end
        chk("dump_finished", 64'(dump_busy), 64'd0);
    endtask

    task automatic run_dump(input int pct, input bit mid_kick, input bit zero_mode,
                            input int exp_beats);
        bit first_is_zero;
        int first_cyc;
        rdy_pct = pct;
        preload(zero_mode);
        expect_dump();
        first_is_zero = (exp_q.size() > 0) && (exp_q[0].idx == '0);
        kick();
        chk("busy_after_kick", 64'(dump_busy), 64'd1);
        chk("addr_after_kick", 64'(ram_addr), 64'd0);
        chk("valid_t1", 64'(out_valid), 64'd0);
        step();
        chk("valid_t1b", 64'(out_valid), 64'd0);
        step();
        first_cyc = cyc;
        chk("valid_t2", 64'(out_valid), 64'(first_is_zero));
        if (first_is_zero) chk("first_index", 64'(out_index), 64'd0);
        wait_idle(mid_kick);
        if (pct == 100 && first_is_zero) chk("busy_drop_lat", 64'(cyc - first_cyc), 64'd16);
        chk("beat_count", 64'(beats), 64'(exp_beats));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_addr", 64'(ram_addr), 64'd0);
        chk("idle_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        dump_kick = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = '0;

        vecs[0] = '{100, 1'b0, 1'b0, 16};
        vecs[1] = '{30,  1'b0, 1'b0, 16};
        vecs[2] = '{100, 1'b1, 1'b0, 16};
        vecs[3] = '{100, 1'b0, 1'b0, 16};
        vecs[4] = '{100, 1'b0, 1'b1, ZeroBeats};
        vecs[5] = '{30,  1'b0, 1'b1, ZeroBeats};

        // Reset state.
        repeat (3) step();
        chk("rst_busy", 64'(dump_busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_index", 64'(out_index), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        reset = 1'b0;
        step();
        mon_en = 1'b1;

        // Scenario table; each dump's kick lands in the first idle cycle after the last.
        for (int v = 0; v < 6; v++) begin
            run_dump(vecs[v].pct, vecs[v].mid_kick, vecs[v].zero_mode, vecs[v].exp_beats);
        end

        // Sink stalled for 10 cycles after the kick: issue stops two indices in.
        rdy_pct = 0;
        preload(1'b0);
        expect_dump();
        kick();
        repeat (10) step();
        chk("stall_addr", 64'(ram_addr), 64'd2);
        chk("stall_addr_hi", 64'(ram_addr[31:AW]), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_index", 64'(out_index), 64'd0);
        chk("stall_data", out_data, 64'h0000_0000_0000_0001);
        rdy_pct = 100;
        wait_idle(1'b0);
        chk("stall_beats", 64'(beats), 64'd16);
        chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with beat 5 at the head, then a clean dump.
        rdy_pct = 100;
        preload(1'b0);
        expect_dump();
        kick();
        for (int c = 0; c < 50 && !(out_valid && out_index == AW'(5)); c++) step();
        chk("reach_beat5", 64'(out_index), 64'd5);
        mon_en = 1'b0;
        reset  = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(dump_busy), 64'd0);
        chk("midrst_last", 64'(out_last), 64'd0);
        chk("midrst_addr", 64'(ram_addr), 64'd0);
        mon_en = 1'b1;
        run_dump(100, 1'b0, 1'b0, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
